// File: rtl/friet_lwc_buffer_in.sv
// Two-entry skid buffer for the LWC receive stream (data + last, valid/ready).
// Both the forward outputs and din_ready come straight from flops, so there is no dout_ready -> din_ready path.
module friet_lwc_buffer_in #(
  parameter int G_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [G_WIDTH-1:0] din,
  input  logic               din_last,
  input  logic               din_valid,
  output logic               din_ready,
  output logic [G_WIDTH-1:0] dout,
  output logic               dout_last,
  output logic               dout_valid,
  input  logic               dout_ready
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_HALF,
    ST_FULL
  } state_t;

  state_t             state, state_nxt;
  logic [G_WIDTH-1:0] m_data, s_data;
  logic               m_last, s_last;
  logic               accept, pop;
  logic               load_m_din, load_m_skid, load_s;

  assign accept = din_valid & din_ready;
  assign pop    = dout_valid & dout_ready;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    load_m_din  = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (accept) begin
          load_m_din = 1'b1;
          state_nxt  = ST_HALF;
        end
      end
      ST_HALF: begin
        if (accept && pop) begin
          load_m_din = 1'b1;
        end else if (accept) begin
          load_s    = 1'b1;
          state_nxt = ST_FULL;
        end else if (pop) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // din_ready is low here, so only the drain of the skid word can happen.
        if (pop) begin
          load_m_skid = 1'b1;
          state_nxt   = ST_HALF;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: both storage words are cleared on reset so dout reads zero and no stale word survives.
      state      <= ST_EMPTY;
      m_data     <= '0;
      m_last     <= 1'b0;
      s_data     <= '0;
      s_last     <= 1'b0;
      din_ready  <= 1'b1;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      din_ready  <= (state_nxt != ST_FULL);
      dout_valid <= (state_nxt != ST_EMPTY);
      if (load_m_din) begin
        m_data <= din;
        m_last <= din_last;
      end else if (load_m_skid) begin
        m_data <= s_data;
        m_last <= s_last;
      end
      if (load_s) begin
        s_data <= din;
        s_last <= din_last;
      end
    end
  end

  assign dout      = m_data;
  assign dout_last = m_last;

endmodule

// File: tb/tb_friet_lwc_buffer_in.sv
// Directed and randomized self-checking bench for friet_lwc_buffer_in.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_friet_lwc_buffer_in;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din = '0;
  logic        din_last = 1'b0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [31:0] dout;
  logic        dout_last;
  logic        dout_valid;
  logic        dout_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [32:0] sb[$];
  int          pushed;
  int          cyc;

  always #5 clk = ~clk;

  friet_lwc_buffer_in #(.G_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_last   (din_last),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_last  (dout_last),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    din       = d;
    din_last  = l;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
  endtask

  initial begin
    // Reset with a word offered: it must be discarded.
    rst       = 1'b1;
    din       = 32'hDEADBEEF;
    din_valid = 1'b1;
    step();
    step();
    rst       = 1'b0;
    din_valid = 1'b0;
    check("rst_valid", 64'(dout_valid), 64'(0));
    check("rst_dout",  64'(dout),       64'(0));
    check("rst_last",  64'(dout_last),  64'(0));
    check("rst_ready", 64'(din_ready),  64'(1));
    step();
    check("rst_no_word", 64'(dout_valid), 64'(0));

    // Back-to-back streaming, one word per cycle.
    dout_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      din       = 32'(i);
      din_last  = (i == 8);
      din_valid = 1'b1;
      step();
      check("str_dout",  64'(dout),       64'(i));
      check("str_valid", 64'(dout_valid), 64'(1));
      check("str_last",  64'(dout_last),  64'(i == 8));
      check("str_ready", 64'(din_ready),  64'(1));
    end
    din_valid = 1'b0;
    din_last  = 1'b0;
    step();
    check("str_drain", 64'(dout_valid), 64'(0));

    // Backpressure: A and B stored, C held upstream.
    dout_ready = 1'b0;
    push(32'hA, 1'b0);
    check("bp_a_dout",  64'(dout),      64'hA);
    check("bp_a_ready", 64'(din_ready), 64'(1));
    push(32'hB, 1'b0);
    check("bp_full_ready", 64'(din_ready), 64'(0));
    check("bp_full_dout",  64'(dout),      64'hA);
    din       = 32'hC;
    din_valid = 1'b1;
    step();
    step();
    check("bp_hold_dout",  64'(dout),       64'hA);
    check("bp_hold_valid", 64'(dout_valid), 64'(1));
    check("bp_hold_ready", 64'(din_ready),  64'(0));
    dout_ready = 1'b1;
    #1;
    check("bp_no_comb_ready", 64'(din_ready), 64'(0));
    step();
    check("bp_out_b", 64'(dout),      64'hB);
    check("bp_ready_back", 64'(din_ready), 64'(1));
    step();
    check("bp_out_c", 64'(dout),       64'hC);
    check("bp_c_valid", 64'(dout_valid), 64'(1));
    din_valid = 1'b0;
    step();
    check("bp_drain", 64'(dout_valid), 64'(0));

    // Simultaneous accept and pop in HALF.
    dout_ready = 1'b0;
    push(32'h11, 1'b0);
    check("sim_m11", 64'(dout), 64'h11);
    din        = 32'h22;
    din_valid  = 1'b1;
    dout_ready = 1'b1;
    step();
    din_valid = 1'b0;
    check("sim_dout",  64'(dout),       64'h22);
    check("sim_valid", 64'(dout_valid), 64'(1));
    check("sim_ready", 64'(din_ready),  64'(1));
    step();
    check("sim_drain", 64'(dout_valid), 64'(0));

    // Reset while FULL drops both words.
    dout_ready = 1'b0;
    push(32'h33, 1'b0);
    push(32'h44, 1'b1);
    check("rf_full", 64'(din_ready), 64'(0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rf_valid", 64'(dout_valid), 64'(0));
    check("rf_ready", 64'(din_ready),  64'(1));
    dout_ready = 1'b1;
    push(32'h55, 1'b0);
    check("rf_first", 64'(dout),       64'h55);
    check("rf_first_valid", 64'(dout_valid), 64'(1));
    check("rf_first_last",  64'(dout_last),  64'(0));
    step();
    check("rf_drain", 64'(dout_valid), 64'(0));

    // Random traffic against a FIFO scoreboard.
    pushed = 0;
    cyc    = 0;
    sb.delete();
    while ((pushed < 10000 || sb.size() > 0) && cyc < 60000) begin
      din_valid  = (pushed < 10000) && ($urandom_range(0, 1) == 1);
      din        = $urandom;
      din_last   = 1'($urandom_range(0, 1));
      dout_ready = ($urandom_range(0, 9) < 3);
      #1;
      check("rnd_ready", 64'(din_ready),  64'(sb.size() < 2));
      check("rnd_valid", 64'(dout_valid), 64'(sb.size() != 0));
      if (dout_valid && dout_ready && sb.size() > 0) begin
        check("rnd_data", 64'(dout),      64'(sb[0][31:0]));
        check("rnd_last", 64'(dout_last), 64'(sb[0][32]));
        void'(sb.pop_front());
      end
      if (din_valid && din_ready) begin
        sb.push_back({din_last, din});
        pushed++;
      end
      step();
      cyc++;
    end
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    check("rnd_timeout", 64'(cyc < 60000), 64'(1));
    check("rnd_pushed",  64'(pushed),      64'(10000));
    check("rnd_empty",   64'(sb.size()),   64'(0));
    check("rnd_end_valid", 64'(dout_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
